// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one gcd datapath unit among
// NUM_REQ requesters. It runs one operation at a time: it accepts a request,
// pulses the gcd unit, waits for the result and holds it until the granted
// requester takes it.
module gcd_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [WIDTH-1:0]         rsp_gcd_o,
    output logic                     gcd_valid_o,
    output logic [WIDTH-1:0]         gcd_a_o,
    output logic [WIDTH-1:0]         gcd_b_o,
    input  logic [WIDTH-1:0]         gcd_result_i,
    input  logic                     gcd_valid_i,
    output logic [ID_W-1:0]          grant_id_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         done_cnt_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    rsp_gcd_q, rsp_gcd_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                found;
    logic [ID_W-1:0]     winner;
    int                  idx;

    // Round-robin pick: first requester after the last grant, wrapping.
    // Resetting grant_q to NUM_REQ-1 makes requester 0 the first choice.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(grant_q) + i) % NUM_REQ;
            if (!found && req_valid_i[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    // Sequencer next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_gcd_d   = rsp_gcd_q;
        rsp_valid_d = rsp_valid_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        req_ready_o = '0;
        gcd_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_o[winner] = 1'b1;
                    a_d     = req_a_i[winner*WIDTH +: WIDTH];
                    b_d     = req_b_i[winner*WIDTH +: WIDTH];
                    grant_d = winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Single-cycle start pulse; operands are already stable.
                gcd_valid_o = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (gcd_valid_i) begin
                    rsp_gcd_d            = gcd_result_i;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end
            end
            RESP: begin
                // Only the granted requester's ready bit can retire the result.
                if (rsp_ready_i[grant_q]) begin
                    rsp_valid_d = '0;
                    cnt_d       = cnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rsp_gcd_q   <= '0;
            rsp_valid_q <= '0;
            grant_q     <= ID_W'(NUM_REQ - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_gcd_q   <= rsp_gcd_d;
            rsp_valid_q <= rsp_valid_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gcd_a_o     = a_q;
    assign gcd_b_o     = b_q;
    assign rsp_gcd_o   = rsp_gcd_q;
    assign rsp_valid_o = rsp_valid_q;
    assign grant_id_o  = grant_q;
    assign busy_o      = (state_q != IDLE);
    assign done_cnt_o  = cnt_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: per-requester operand queues drive the request
// side, a behavioural gcd unit answers with random latency (plus stray
// result pulses when idle), and a scoreboard checks responses and counters.
module tb_gcd_arbiter;
    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_W   = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic [NUM_REQ-1:0]       req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [NUM_REQ*WIDTH-1:0] req_a_i, req_b_i;
    logic [WIDTH-1:0]         rsp_gcd_o, gcd_a_o, gcd_b_o, gcd_result_i;
    logic                     gcd_valid_o, gcd_valid_i, busy_o;
    logic [ID_W-1:0]          grant_id_o;
    logic [CNT_W-1:0]         done_cnt_o;

    always #5 clk_i = ~clk_i;

    gcd_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_gcd_o(rsp_gcd_o),
        .gcd_valid_o(gcd_valid_o), .gcd_a_o(gcd_a_o), .gcd_b_o(gcd_b_o),
        .gcd_result_i(gcd_result_i), .gcd_valid_i(gcd_valid_i),
        .grant_id_o(grant_id_o), .busy_o(busy_o), .done_cnt_o(done_cnt_o)
    );

    typedef struct { int id; int res; } exp_t;

    int   checks = 0, failures = 0;
    exp_t sbq[$];
    int   opa[NUM_REQ][256], opb[NUM_REQ][256];
    int   head[NUM_REQ], tail[NUM_REQ];
    int   last_grant = NUM_REQ - 1;
    int   exp_cnt = 0;
    bit   hs_now = 1'b0;
    bit   rsp_rand = 1'b0;
    bit   force_long = 1'b0;
    bit   pending = 1'b0;
    int   bp_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin t = y; y = x % y; x = t; end
        return x;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int i = 1; i <= NUM_REQ; i++)
            if (v[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int k = 0; k < NUM_REQ; k++) if (head[k] != tail[k]) return 1'b0;
        return sbq.size() == 0;
    endfunction

    task automatic push(input int k, input int a, input int b);
        opa[k][tail[k]] = a;
        opb[k][tail[k]] = b;
        tail[k]++;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (n < budget) begin
            @(negedge clk_i); #3;
            if (all_empty()) break;
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL timeout_%s actual=busy required=idle within %0d cycles", tag, budget);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_gcd", rsp_gcd_o, 0);
        chk("rst_gcd_valid", gcd_valid_o, 0);
        chk("rst_gcd_a", gcd_a_o, 0);
        chk("rst_gcd_b", gcd_b_o, 0);
        chk("rst_grant_id", grant_id_o, NUM_REQ - 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done_cnt", done_cnt_o, 0);
    endtask

    // Request/response-ready driver: presents the head of each operand queue.
    initial begin
        req_valid_i = '0; req_a_i = '0; req_b_i = '0; rsp_ready_i = '1;
        forever begin
            @(posedge clk_i); #1;
            for (int k = 0; k < NUM_REQ; k++) begin
                req_valid_i[k] = (head[k] < tail[k]);
                req_a_i[k*WIDTH +: WIDTH] = WIDTH'(opa[k][head[k]]);
                req_b_i[k*WIDTH +: WIDTH] = WIDTH'(opb[k][head[k]]);
            end
            rsp_ready_i = rsp_rand ? NUM_REQ'($urandom) : '1;
            if (bp_cnt > 0) begin
                rsp_ready_i[2] = 1'b0;
                if (rsp_valid_o[2]) bp_cnt--;
            end
        end
    end

    // Request-side checker: arbitration model, pushes expected results.
    initial begin
        forever begin
            @(negedge clk_i);
            hs_now = 1'b0;
            if (rst_i) begin
                for (int k = 0; k < NUM_REQ; k++) head[k] = tail[k];
                sbq.delete();
                last_grant = NUM_REQ - 1;
            end else begin
                int w;
                logic [NUM_REQ-1:0] exp_rdy;
                chk("grant_id", grant_id_o, last_grant);
                w = rr_pick(req_valid_i, last_grant);
                exp_rdy = '0;
                if (sbq.size() == 0 && w >= 0) exp_rdy[w] = 1'b1;
                chk("req_ready", req_ready_o, exp_rdy);
                if (exp_rdy != '0) begin
                    sbq.push_back('{w, ref_gcd(opa[w][head[w]], opb[w][head[w]])});
                    head[w]++;
                    last_grant = w;
                    hs_now = 1'b1;
                end
            end
        end
    end

    // Response monitor: compares presented results against the scoreboard.
    initial begin
        forever begin
            @(negedge clk_i); #2;
            if (rst_i) begin
                exp_cnt = 0;
            end else begin
                chk("done_cnt", done_cnt_o, exp_cnt);
                chk("busy", busy_o, (sbq.size() != 0) && !hs_now);
                if (rsp_valid_o != '0) begin
                    if (sbq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rsp_spurious actual=%b required=0", rsp_valid_o);
                    end else begin
                        chk("rsp_valid", rsp_valid_o, 1 << sbq[0].id);
                        chk("rsp_gcd", rsp_gcd_o, sbq[0].res);
                        if (rsp_ready_i[sbq[0].id]) begin
                            void'(sbq.pop_front());
                            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
                        end
                    end
                end
            end
        end
    end

    // Behavioural gcd unit: random latency, stray result pulses when idle.
    initial begin
        int lat, res;
        bit nxt_v;
        int nxt_r;
        gcd_valid_i = 1'b0; gcd_result_i = '0;
        lat = 0; res = 0;
        forever begin
            @(negedge clk_i);
            nxt_v = 1'b0;
            nxt_r = 0;
            if (rst_i) begin
                pending = 1'b0;
            end else if (gcd_valid_o) begin
                chk("issue_while_busy", pending, 0);
                pending = 1'b1;
                res = ref_gcd(gcd_a_o, gcd_b_o);
                lat = force_long ? 20 : $urandom_range(0, 5);
            end else if (pending) begin
                if (lat == 0) begin
                    nxt_v = 1'b1; nxt_r = res; pending = 1'b0;
                end else lat--;
            end else begin
                nxt_v = ($urandom_range(0, 5) == 0);
                nxt_r = $urandom_range(0, 255);
            end
            @(posedge clk_i); #1;
            gcd_valid_i  = nxt_v;
            gcd_result_i = WIDTH'(nxt_r);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        for (int k = 0; k < NUM_REQ; k++) begin head[k] = 0; tail[k] = 0; end
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i); #3;
        check_reset_values();

        // single request
        push(0, 18, 12);
        wait_idle(100, "single");

        // all four requesting together, requester 0 twice
        push(0, 6, 2); push(1, 9, 12); push(2, 18, 12); push(3, 7, 5); push(0, 20, 8);
        wait_idle(300, "all_four");

        // response backpressure on requester 2 plus a waiting competitor
        bp_cnt = 10;
        push(2, 18, 12);
        @(negedge clk_i); #3;
        push(1, 9, 6);
        wait_idle(200, "backpressure");
        chk("bp_consumed", bp_cnt, 0);

        // zero operands
        push(1, 0, 15); push(3, 0, 0);
        wait_idle(200, "zero");

        // reset while waiting on the gcd unit
        force_long = 1'b1;
        push(0, 100, 75);
        n = 0;
        while (!pending && n < 50) begin @(negedge clk_i); #3; n++; end
        chk("reached_wait", pending, 1);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        force_long = 1'b0;
        @(negedge clk_i); #3;
        check_reset_values();
        push(0, 21, 14);
        wait_idle(100, "after_reset");

        // randomized traffic with random response backpressure
        rsp_rand = 1'b1;
        for (int batch = 0; batch < 4; batch++) begin
            for (int i = 0; i < 40; i++)
                push($urandom_range(0, NUM_REQ - 1),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255));
            wait_idle(3000, "random");
        end
        rsp_rand = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
Round-robin arbiter and sequencer that shares one gcd datapath unit among NUM_REQ requesters. Each requester offers an operand pair over a valid/ready handshake. The arbiter issues one operation at a time to the gcd unit, waits for its result, and returns the result to the granted requester over a held valid/ready response. It sits between the requester clients and a single gcd instance; it also reports busy state and a completion count.

Parameters:
WIDTH, 8, operand/result width; must match the attached gcd unit
NUM_REQ, 4, number of requesters (2..16)
ID_W, $clog2(NUM_REQ), requester index width
CNT_W, 16, completion counter width

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  NUM_REQ  per-requester operation request
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
req_a_i  in  NUM_REQ*WIDTH  packed operand a; slice k belongs to requester k
req_b_i  in  NUM_REQ*WIDTH  packed operand b; slice k belongs to requester k
rsp_valid_o  out  NUM_REQ  per-requester result valid; one-hot or zero
rsp_ready_i  in  NUM_REQ  per-requester result accept
rsp_gcd_o  out  WIDTH  result (shared bus; qualified by rsp_valid_o)
gcd_valid_o  out  1  start pulse to gcd unit valid_i
gcd_a_o  out  WIDTH  operand a to gcd unit
gcd_b_o  out  WIDTH  operand b to gcd unit
gcd_result_i  in  WIDTH  gcd unit gcd_o
gcd_valid_i  in  1  gcd unit valid_o
grant_id_o  out  ID_W  index of current/last granted requester
busy_o  out  1  high in any state other than IDLE
done_cnt_o  out  CNT_W  completed transactions, wraps modulo 2^CNT_W

Behaviour:
- Reset (sync, rst_i=1 at clock edge): state=IDLE; req_ready_o=0, rsp_valid_o=0, rsp_gcd_o=0, gcd_valid_o=0, gcd_a_o=0, gcd_b_o=0, grant_id_o=NUM_REQ-1, busy_o=0, done_cnt_o=0. The round-robin pointer is set so requester 0 has highest priority first. An in-flight transaction is dropped with no response. The gcd unit is reset by the same rst_i.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first k with req_valid_i[k]=1, scanning from (grant_id_o+1) mod NUM_REQ upward and wrapping.
  - req_ready_o[winner]=1 combinationally, same cycle; handshake completes that cycle.
  - At the edge: latch a/b slices into gcd_a_o/gcd_b_o, set grant_id_o=winner, go to ISSUE.
  - No request: stay in IDLE, outputs unchanged except the ready bits (0).
- ISSUE: gcd_valid_o=1 for exactly this one cycle, with gcd_a_o/gcd_b_o stable; go to WAIT.
- WAIT:
  - gcd_valid_o=0; gcd_a_o/gcd_b_o held.
  - On gcd_valid_i=1: rsp_gcd_o<=gcd_result_i, rsp_valid_o<=one-hot(grant_id_o), go to RESP.
  - No timeout.
- RESP:
  - rsp_valid_o and rsp_gcd_o held until rsp_ready_i[grant_id_o]=1.
  - At that edge: rsp_valid_o<=0, done_cnt_o+=1 (wrap), go to IDLE.
  - rsp_ready_i bits of other requesters are ignored.
- req_ready_o is 0 in ISSUE/WAIT/RESP; requests there are held by the requester, not dropped.
- Minimum spacing: the next gcd_valid_o is at least 2 cycles after gcd_valid_i (RESP + IDLE). This guarantees the gcd unit has returned to idle.
- Operands pass unmodified. Zero operands are forwarded; the result is whatever the gcd unit returns (gcd(0,x)=x, gcd(0,0)=0).
- gcd_valid_i outside WAIT is ignored.
- Arbitration is fair: a continuously requesting k is granted within NUM_REQ grants.

Test Plan:
- Single request: requester 0, a=18, b=12 -> req_ready_o=0001 same cycle; gcd_valid_o one-cycle pulse next cycle; rsp_valid_o=0001 with rsp_gcd_o=6; done_cnt_o=1 after rsp_ready_i[0].
- All four requesting continuously after reset, operands (6,2),(9,12),(18,12),(7,5) -> grants in order 0,1,2,3,0; results 2,3,6,1 to matching rsp_valid_o bit.
- Response backpressure: rsp_ready_i[2]=0 for 10 cycles, result 6 -> rsp_valid_o=0100 and rsp_gcd_o=6 stable all 10 cycles; no new req_ready_o; next grant only after accept.
- Zero operands: (0,15) -> rsp_gcd_o=15; (0,0) -> rsp_gcd_o=0; each completes normally.
- Reset mid-operation: rst_i for 1 cycle while in WAIT -> next cycle all outputs at reset values, no rsp_valid_o for the dropped op; next request from requester 0 completes normally.
- Counter wrap with CNT_W=2: 5 transactions -> done_cnt_o sequence 1,2,3,0,1.
